// File: rtl/instr_mem_param.sv
// -----------------------------------------------------------------------------
// instr_mem_param
//   Parametrised instruction memory for the CPU fetch path.
//   - Fetch port: synchronous, registered, fixed 1-cycle latency, with a
//     stall input (fetch_hold) that freezes all fetch outputs.
//   - Load port: streaming burst writer driven by a two-state FSM with an
//     auto-incrementing, saturating write pointer starting at load_base.
//   Both ports run fully concurrently. Addresses >= DEPTH are range-checked
//   on both ports (dropped writes set load_err, fetches set addr_err).
//
// Optional build macro:
//   IMEM_BYPASS_EN - when defined, a fetch that hits the address being
//                    written in the same cycle returns load_data
//                    (write-first). Undefined: read-before-write.
//
// Parameters:
//   DATA_W      instruction word width
//   ADDR_W      address width
//   DEPTH       implemented words, 1 <= DEPTH <= 2**ADDR_W
//   RESET_CLEAR 1: array cleared on reset, 0: array untouched by reset
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   load_start, load_base    open/restart a load session at load_base
//   load_valid, load_data,
//   load_last                word stream; load_last marks the final word
//   load_ready, load_busy    loader accepting / session open
//   load_err, load_count     sticky drop flag / words written this session
//   fetch_req, fetch_addr,
//   fetch_hold               fetch request, address, stall
//   instr_valid, instruction,
//   addr_err                 fetch result of the previous cycle
// -----------------------------------------------------------------------------
module instr_mem_param #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int RESET_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_hold,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              addr_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_nxt_s;
  // Set once the pointer has tried to step past PTR_MAX; every later word
  // in the session is dropped even if PTR_MAX itself is a valid address.
  logic              sat_r;
  logic              sat_nxt_s;
  logic [ADDR_W:0]   load_count_r;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              load_err_r;
  logic              err_nxt_s;
  logic              load_busy_r;
  logic              load_ready_r;
  logic              wr_en_s;
  logic              ptr_in_rng_s;
  logic              fetch_in_rng_s;
  logic [DATA_W-1:0] rd_word_s;

  logic              instr_valid_r;
  logic [DATA_W-1:0] instruction_r;
  logic              addr_err_r;

  assign ptr_in_rng_s   = ({1'b0, ptr_r} < DEPTH_L);
  assign fetch_in_rng_s = ({1'b0, fetch_addr} < DEPTH_L);

  // Loader next-state, pointer, counter and error logic
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    sat_nxt_s   = sat_r;
    cnt_nxt_s   = load_count_r;
    err_nxt_s   = load_err_r;
    wr_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt_s = ST_LOAD;
          ptr_nxt_s   = load_base;
          sat_nxt_s   = 1'b0;
          cnt_nxt_s   = '0;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A restart takes priority; a word offered in the same cycle is ignored.
        if (load_start) begin
          state_nxt_s = ST_LOAD;
          ptr_nxt_s   = load_base;
          sat_nxt_s   = 1'b0;
          cnt_nxt_s   = '0;
          err_nxt_s   = 1'b0;
        end else if (load_valid) begin
          if (!sat_r && ptr_in_rng_s) begin
            wr_en_s   = 1'b1;
            cnt_nxt_s = load_count_r + CNT_ONE;
          end else begin
            err_nxt_s = 1'b1;
          end
          if (ptr_r == PTR_MAX) begin
            sat_nxt_s = 1'b1;
          end else begin
            ptr_nxt_s = ptr_r + PTR_ONE;
          end
          if (load_last) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Loader state register and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      sat_r        <= 1'b0;
      load_count_r <= '0;
      load_err_r   <= 1'b0;
      load_busy_r  <= 1'b0;
      load_ready_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      sat_r        <= sat_nxt_s;
      load_count_r <= cnt_nxt_s;
      load_err_r   <= err_nxt_s;
      load_busy_r  <= (state_nxt_s == ST_LOAD);
      load_ready_r <= (state_nxt_s == ST_LOAD);
    end
  end

  generate
    if (RESET_CLEAR != 0) begin : g_mem_clr
      // Array write port, cleared by reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
          end
        end else if (wr_en_s) begin
          mem_r[ptr_r] <= load_data;
        end
      end
    end else begin : g_mem_keep
      // Array write port, contents survive reset
      always_ff @(posedge clk) begin
        if (wr_en_s) begin
          mem_r[ptr_r] <= load_data;
        end
      end
    end
  endgenerate

  // Read data selection (old array word, or the word being written)
  always_comb begin
    rd_word_s = mem_r[fetch_addr];
`ifdef IMEM_BYPASS_EN
    if (wr_en_s && (ptr_r == fetch_addr)) begin
      rd_word_s = load_data;
    end else begin
      rd_word_s = mem_r[fetch_addr];
    end
`endif
  end

  // Fetch port output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_r <= 1'b0;
      instruction_r <= '0;
      addr_err_r    <= 1'b0;
    end else if (fetch_hold) begin
      instr_valid_r <= instr_valid_r;
      instruction_r <= instruction_r;
      addr_err_r    <= addr_err_r;
    end else if (fetch_req) begin
      instr_valid_r <= 1'b1;
      if (fetch_in_rng_s) begin
        instruction_r <= rd_word_s;
        addr_err_r    <= 1'b0;
      end else begin
        instruction_r <= '0;
        addr_err_r    <= 1'b1;
      end
    end else begin
      instr_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
    end
  end

  assign load_ready  = load_ready_r;
  assign load_busy   = load_busy_r;
  assign load_err    = load_err_r;
  assign load_count  = load_count_r;
  assign instr_valid = instr_valid_r;
  assign instruction = instruction_r;
  assign addr_err    = addr_err_r;

endmodule
